// File: rtl/spn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spn_pkg
// Brief    : Shared types, S-box tables and word-level helpers for the SPN core.
// Revision : 1.0 - initial release
// ============================================================================
package spn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        R1   = 2'd1,
        R2   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
        4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'hE, 4'h3, 4'h4, 4'h8, 4'h1, 4'hC, 4'hA, 4'hF,
        4'h7, 4'hD, 4'h9, 4'h6, 4'hB, 4'h2, 4'h0, 4'h5
    };

    function automatic logic [15:0] sub16(input logic [15:0] x);
        logic [15:0] r;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            r[4*n +: 4] = SBOX[x[4*n +: 4]];
        end
        return r;
    endfunction

    function automatic logic [15:0] inv_sub16(input logic [15:0] x);
        logic [15:0] r;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            r[4*n +: 4] = SBOX_INV[x[4*n +: 4]];
        end
        return r;
    endfunction

    // Bit transpose of the 4x4 nibble matrix; applying it twice is identity.
    function automatic logic [15:0] perm16(input logic [15:0] x);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                r[4*j + i] = x[4*i + j];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spn_sbox4.sv
`default_nettype none
// ============================================================================
// Module   : spn_sbox4
// Brief    : Combinational 4-bit S-box with forward/inverse select.
// Revision : 1.0 - initial release
// ============================================================================
module spn_sbox4
    import spn_pkg::*;
(
    input  logic [3:0] din,
    input  logic       inv,
    output logic [3:0] dout
);

    assign dout = inv ? SBOX_INV[din] : SBOX[din];

endmodule
`default_nettype wire

// File: rtl/spn_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : spn_round_engine
// Brief    : Iterative two-round 16-bit SPN encrypt/decrypt datapath.
// Revision : 1.0 - initial release
// ============================================================================
module spn_round_engine
    import spn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [DATA_W-1:0] round_keys [0:2],
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int NUM_SBOX = DATA_W / NIB_W;

    generate
        if (DATA_W != 16 || NIB_W != 4) begin : g_width_check
            $error("spn_round_engine supports only DATA_W=16 with NIB_W=4");
        end
    endgenerate

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_k1;
    logic [DATA_W-1:0] r_k2;
    logic              r_mode;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [DATA_W-1:0] w_sbox_in;
    logic [DATA_W-1:0] w_sbox_out;
    logic [DATA_W-1:0] w_round_key;
    logic [DATA_W-1:0] w_round;

    // Decrypt round 2 undoes the permutation before substitution; all other
    // rounds feed the S-boxes directly, so one S-box bank serves both modes.
    assign w_sbox_in = (r_state == R2 && r_mode) ? perm16(r_data) : r_data;

    genvar g;
    generate
        for (g = 0; g < NUM_SBOX; g++) begin : g_sbox
            spn_sbox4 u_sbox (
                .din  (w_sbox_in[g*NIB_W +: NIB_W]),
                .inv  (r_mode),
                .dout (w_sbox_out[g*NIB_W +: NIB_W])
            );
        end
    endgenerate

    assign w_round_key = (r_state == R1) ? r_k1 : r_k2;
    assign w_round     = ((r_state == R1 && !r_mode) ? perm16(w_sbox_out) : w_sbox_out)
                         ^ w_round_key;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_k1        <= '0;
            r_k2        <= '0;
            r_mode      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data     <= in_data ^ round_keys[0];
                        r_k1       <= round_keys[1];
                        r_k2       <= round_keys[2];
                        r_mode     <= mode;
                        r_state    <= R1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                R1: begin
                    r_data  <= w_round;
                    r_state <= R2;
                end
                R2: begin
                    r_data      <= w_round;
                    r_state     <= DONE;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_spn_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_spn_round_engine
// Brief    : Self-checking bench for spn_round_engine against a reference cipher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spn_round_engine;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [15:0] round_keys [0:2];
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] tb_sbox [16] = '{
        4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
        4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7
    };

    spn_round_engine #(.DATA_W(16), .NIB_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .round_keys (round_keys),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: nibble lookup, inverse found by table search.
    function automatic logic [3:0] m_s(input logic [3:0] x, input bit inv);
        logic [3:0] r;
        r = 4'h0;
        if (!inv) r = tb_sbox[x];
        else begin
            for (int v = 0; v < 16; v++) begin
                if (tb_sbox[v] == x) r = 4'(v);
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] m_sub(input logic [15:0] x, input bit inv);
        logic [15:0] r;
        r = '0;
        for (int n = 0; n < 4; n++) r[4*n +: 4] = m_s(x[4*n +: 4], inv);
        return r;
    endfunction

    function automatic logic [15:0] m_perm(input logic [15:0] x);
        logic [15:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) r[(b % 4) * 4 + b / 4] = x[b];
        return r;
    endfunction

    function automatic logic [15:0] m_cipher(input bit m, input logic [15:0] k0,
                                             input logic [15:0] k1, input logic [15:0] k2,
                                             input logic [15:0] d);
        logic [15:0] t;
        t = d ^ k0;
        if (!m) begin
            t = m_perm(m_sub(t, 0)) ^ k1;
            t = m_sub(t, 0) ^ k2;
        end else begin
            t = m_sub(t, 1) ^ k1;
            t = m_sub(m_perm(t), 1) ^ k2;
        end
        return t;
    endfunction

    // Bench-side key scheduler: three overlapping slices, reversed for decrypt.
    task automatic sched(input logic [31:0] key, input bit dec,
                         output logic [15:0] k0, output logic [15:0] k1, output logic [15:0] k2);
        if (!dec) begin
            k0 = key[31:16]; k1 = key[23:8]; k2 = key[15:0];
        end else begin
            k0 = key[15:0];  k1 = key[23:8]; k2 = key[31:16];
        end
    endtask

    // Called at posedge+1 with the engine idle. toggle scrambles inputs while
    // busy; hold keeps out_ready low for that many cycles in DONE.
    task automatic run_txn(input bit m, input logic [15:0] k0, input logic [15:0] k1,
                           input logic [15:0] k2, input logic [15:0] d,
                           input bit toggle, input int hold, output logic [15:0] res);
        int lat;
        mode = m; round_keys[0] = k0; round_keys[1] = k1; round_keys[2] = k2;
        in_data = d; in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            check("busy_in_flight", busy, 1);
            check("in_ready_in_flight", in_ready, 0);
            if (toggle) begin
                mode = 1'($urandom);
                for (int k = 0; k < 3; k++) round_keys[k] = 16'($urandom);
                in_data  = 16'($urandom);
                in_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 3);
        res = out_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, res);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("in_ready_done_outready", in_ready, 0);
        check("busy_done", busy, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_take", out_valid, 0);
        check("in_ready_after_take", in_ready, 1);
    endtask

    initial begin
        logic [15:0] k0, k1, k2, d, ct, pt, exp;
        logic [31:0] key;
        bit          m;

        reset = 1'b1; mode = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) round_keys[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 16'h0000);

        run_txn(0, 16'h0, 16'h0, 16'h0, 16'h0000, 0, 0, ct);
        check("enc_zero", ct, 16'h777E);
        run_txn(1, 16'h0, 16'h0, 16'h0, 16'h777E, 0, 0, pt);
        check("dec_zero", pt, 16'h0000);

        key = 32'hA5A51234;
        sched(key, 0, k0, k1, k2);
        run_txn(0, k0, k1, k2, 16'h3C5A, 0, 0, ct);
        check("rt_fixed_ct", ct, m_cipher(0, k0, k1, k2, 16'h3C5A));
        sched(key, 1, k0, k1, k2);
        run_txn(1, k0, k1, k2, ct, 0, 0, pt);
        check("rt_fixed_pt", pt, 16'h3C5A);

        for (int i = 0; i < 1000; i++) begin
            key = $urandom;
            d   = 16'($urandom);
            sched(key, 0, k0, k1, k2);
            run_txn(0, k0, k1, k2, d, 0, 0, ct);
            check("rt_rand_ct", ct, m_cipher(0, k0, k1, k2, d));
            sched(key, 1, k0, k1, k2);
            run_txn(1, k0, k1, k2, ct, 0, 0, pt);
            check("rt_rand_pt", pt, d);
        end

        // Inputs scrambled every clock after accept, random back-pressure.
        for (int i = 0; i < 60; i++) begin
            m  = 1'($urandom);
            k0 = 16'($urandom); k1 = 16'($urandom); k2 = 16'($urandom);
            d  = 16'($urandom);
            exp = m_cipher(m, k0, k1, k2, d);
            run_txn(m, k0, k1, k2, d, 1, int'($urandom_range(0, 3)), ct);
            check("toggle_result", ct, exp);
        end

        k0 = 16'h1357; k1 = 16'h2468; k2 = 16'hBEEF; d = 16'hCAFE;
        run_txn(0, k0, k1, k2, d, 0, 10, ct);
        check("bp_result", ct, m_cipher(0, k0, k1, k2, d));

        // Reset while in R1 discards the block.
        mode = 1'b0; round_keys[0] = 16'hFFFF; round_keys[1] = 16'h0F0F; round_keys[2] = 16'h00FF;
        in_data = 16'h1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_r1_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_data", out_data, 16'h0000);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        k0 = 16'h4242; k1 = 16'h9999; k2 = 16'h0001; d = 16'h8001;
        run_txn(1, k0, k1, k2, d, 0, 0, pt);
        check("post_rst_result", pt, m_cipher(1, k0, k1, k2, d));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
